// File: rtl/pe_array_feeder.sv
// pe_array_feeder: buffers one ROWS x K tile and streams it diagonally into pe_8x8_cluster
// Ports:
//   clk, rst                 clock, synchronous active-high reset (overrides en_i)
//   en_i                     global enable; 0 freezes all state and outputs
//   start_i, cfg_k_i         tile start request and reduction length K (1..MAX_K)
//   load_valid_i/ready_o     serial load handshake, one act/wgt word pair per beat
//   load_act_i, load_wgt_i   activation and weight words of the current beat
//   activations_o, weights_o skewed lanes to the cluster, lane r at [r*DATA_W +: DATA_W]
//   done_o                   sticky per-row done flags to the cluster
//   cluster_dones_i          cluster completion flags; only the last row is observed
//   busy_o, finished_o       status and one-cycle completion pulse to the controller
//   cfg_err_o, timeout_err_o rejected-start pulse and sticky drain timeout flag
module pe_array_feeder #(
    parameter int ROWS    = 8,
    parameter int DATA_W  = 16,
    parameter int MAX_K   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic                   start_i,
    input  logic [3:0]             cfg_k_i,
    input  logic                   load_valid_i,
    output logic                   load_ready_o,
    input  logic [DATA_W-1:0]      load_act_i,
    input  logic [DATA_W-1:0]      load_wgt_i,
    output logic [ROWS*DATA_W-1:0] activations_o,
    output logic [ROWS*DATA_W-1:0] weights_o,
    output logic [ROWS-1:0]        done_o,
    input  logic [ROWS-1:0]        cluster_dones_i,
    output logic                   busy_o,
    output logic                   finished_o,
    output logic                   cfg_err_o,
    output logic                   timeout_err_o
);
    localparam int CW = $clog2(MAX_K);
    localparam int RW = $clog2(ROWS);
    localparam int DW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, FIN} state_t;

    state_t                   state_q, state_d;
    logic [3:0]               k_q, k_d;
    logic [RW-1:0]            row_q, row_d;
    logic [CW-1:0]            col_q, col_d;
    logic [4:0]               t_q, t_d;
    logic [DW-1:0]            dcnt_q, dcnt_d;
    logic                     cfg_err_d, timeout_err_d;
    logic [ROWS*DATA_W-1:0]   act_q, act_d, wgt_q, wgt_d;
    logic [ROWS-1:0]          done_q, done_d;
    logic                     load_ready_q, busy_q, finished_q, cfg_err_q, timeout_err_q;
    logic [DATA_W-1:0]        act_mem [ROWS][MAX_K];
    logic [DATA_W-1:0]        wgt_mem [ROWS][MAX_K];
    logic                     beat, last_col, last_beat, k_ok;
    logic                     unused_dones;

    // Only the last cluster row signals tile completion.
    assign unused_dones = ^cluster_dones_i[ROWS-2:0];

    assign beat      = load_ready_q & load_valid_i & en_i;
    assign last_col  = 4'(col_q) == k_q - 4'd1;
    assign last_beat = last_col && row_q == RW'(ROWS-1);
    assign k_ok      = cfg_k_i != 4'd0 && cfg_k_i <= 4'(MAX_K);

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        row_d         = row_q;
        col_d         = col_q;
        t_d           = t_q;
        dcnt_d        = dcnt_q;
        cfg_err_d     = 1'b0;
        timeout_err_d = timeout_err_q;
        case (state_q)
            IDLE: begin
                if (start_i && k_ok) begin
                    state_d       = LOAD;
                    k_d           = cfg_k_i;
                    row_d         = '0;
                    col_d         = '0;
                    timeout_err_d = 1'b0;
                end
                cfg_err_d = start_i && !k_ok;
            end
            LOAD: begin
                if (beat) begin
                    col_d = last_col ? '0 : col_q + 1'b1;
                    row_d = last_col ? row_q + 1'b1 : row_q;
                    if (last_beat) begin
                        state_d = STREAM;
                        t_d     = '0;
                    end
                end
            end
            STREAM: begin
                // Last lane finishes its K words at t = ROWS-1+K.
                if (t_q == 5'(ROWS-1) + {1'b0, k_q}) begin
                    state_d = DRAIN;
                    dcnt_d  = '0;
                end else begin
                    t_d = t_q + 5'd1;
                end
            end
            DRAIN: begin
                if (cluster_dones_i[ROWS-1]) begin
                    state_d = FIN;
                end else if (dcnt_q == DW'(TIMEOUT-1)) begin
                    state_d       = FIN;
                    timeout_err_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane outputs are computed from the next state so the registered lanes line up with t.
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [4:0] d;
        logic       on;
        assign d  = t_d - 5'(r);
        assign on = state_d == STREAM && t_d >= 5'(r) && d < {1'b0, k_q};
        assign act_d[r*DATA_W +: DATA_W] = on ? act_mem[r][d[CW-1:0]] : '0;
        assign wgt_d[r*DATA_W +: DATA_W] = on ? wgt_mem[r][d[CW-1:0]] : '0;
        assign done_d[r] = state_d == DRAIN || (state_d == STREAM && t_d >= {1'b0, k_q} + 5'(r));
    end

    always_ff @(posedge clk) begin
        if (beat) begin
            act_mem[row_q][col_q] <= load_act_i;
            wgt_mem[row_q][col_q] <= load_wgt_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            k_q           <= '0;
            row_q         <= '0;
            col_q         <= '0;
            t_q           <= '0;
            dcnt_q        <= '0;
            act_q         <= '0;
            wgt_q         <= '0;
            done_q        <= '0;
            load_ready_q  <= 1'b0;
            busy_q        <= 1'b0;
            finished_q    <= 1'b0;
            cfg_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else if (en_i) begin
            state_q       <= state_d;
            k_q           <= k_d;
            row_q         <= row_d;
            col_q         <= col_d;
            t_q           <= t_d;
            dcnt_q        <= dcnt_d;
            act_q         <= act_d;
            wgt_q         <= wgt_d;
            done_q        <= done_d;
            load_ready_q  <= state_d == LOAD;
            busy_q        <= state_d != IDLE;
            finished_q    <= state_d == FIN;
            cfg_err_q     <= cfg_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign load_ready_o  = load_ready_q & en_i;
    assign activations_o = act_q;
    assign weights_o     = wgt_q;
    assign done_o        = done_q;
    assign busy_o        = busy_q;
    assign finished_o    = finished_q;
    assign cfg_err_o     = cfg_err_q;
    assign timeout_err_o = timeout_err_q;
endmodule

// File: tb/tb_pe_array_feeder.sv
// tb_pe_array_feeder: directed self-checking bench for pe_array_feeder
module tb_pe_array_feeder;
    logic         clk = 1'b0;
    logic         rst, en, start, load_valid, load_ready;
    logic [3:0]   cfg_k;
    logic [15:0]  load_act, load_wgt;
    logic [127:0] activations, weights;
    logic [7:0]   done, cluster_dones;
    logic         busy, finished, cfg_err, timeout_err;
    int           passed = 0, total = 0;

    pe_array_feeder dut (
        .clk(clk), .rst(rst), .en_i(en), .start_i(start), .cfg_k_i(cfg_k),
        .load_valid_i(load_valid), .load_ready_o(load_ready),
        .load_act_i(load_act), .load_wgt_i(load_wgt),
        .activations_o(activations), .weights_o(weights), .done_o(done),
        .cluster_dones_i(cluster_dones), .busy_o(busy), .finished_o(finished),
        .cfg_err_o(cfg_err), .timeout_err_o(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [127:0] lanes(input int t, input int k, input int base);
        logic [127:0] v = '0;
        for (int r = 0; r < 8; r++)
            if (t >= r && t - r < k) v[r*16 +: 16] = 16'(base + r*k + (t - r));
        return v;
    endfunction

    function automatic logic [7:0] dones(input int t, input int k);
        logic [7:0] v = '0;
        for (int r = 0; r < 8; r++) v[r] = t >= r + k;
        return v;
    endfunction

    task automatic check_stream(input int t, input int k, input int ba, input int bw);
        chk($sformatf("act t=%0d", t), activations, lanes(t, k, ba));
        chk($sformatf("wgt t=%0d", t), weights, lanes(t, k, bw));
        chk($sformatf("done t=%0d", t), {120'b0, done}, {120'b0, dones(t, k)});
        chk($sformatf("busy t=%0d", t), {127'b0, busy}, 128'd1);
    endtask

    task automatic start_tile(input logic [3:0] k);
        start = 1'b1; cfg_k = k;
        tick();
        start = 1'b0;
        chk("start_ready", {127'b0, load_ready}, 128'd1);
        chk("start_busy", {127'b0, busy}, 128'd1);
    endtask

    task automatic load_tile(input int k, input int ba, input int bw, input int gap_after);
        for (int n = 0; n < 8*k; n++) begin
            chk($sformatf("ready n=%0d", n), {127'b0, load_ready}, 128'd1);
            load_valid = 1'b1; load_act = 16'(ba + n); load_wgt = 16'(bw + n);
            tick();
            if (n == gap_after) begin
                load_valid = 1'b0; load_act = 16'hDEAD; load_wgt = 16'hBEEF;
                for (int g = 0; g < 5; g++) begin
                    chk("gap_ready", {127'b0, load_ready}, 128'd1);
                    if (g == 2) begin
                        en = 1'b0;
                        #1 chk("gap_en0_ready", {127'b0, load_ready}, 128'd0);
                        tick();
                        en = 1'b1;
                        #1;
                    end else tick();
                end
            end
        end
        // Keep valid asserted with junk: no further beat may be taken.
        load_valid = 1'b1; load_act = 16'hDEAD; load_wgt = 16'hBEEF;
        chk("ready_drop", {127'b0, load_ready}, 128'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0; cfg_k = 4'd0; load_valid = 1'b0;
        load_act = '0; load_wgt = '0; cluster_dones = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_act", activations, '0);
        chk("rst_done", {120'b0, done}, '0);
        chk("rst_status", {123'b0, busy, finished, cfg_err, timeout_err, load_ready}, '0);

        // Tile K=4, stream 12 cycles, cluster completes 3 cycles into DRAIN.
        start_tile(4'd4);
        load_tile(4, 'h0100, 'h0200, -1);
        load_valid = 1'b0;
        for (int t = 0; t < 12; t++) begin
            check_stream(t, 4, 'h0100, 'h0200);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            chk("drain_done", {120'b0, done}, {120'b0, 8'hFF});
            chk("drain_lanes", activations | weights, '0);
            chk("drain_fin", {127'b0, finished}, '0);
            if (i < 3) tick();
        end
        cluster_dones = 8'h80;
        tick();
        cluster_dones = 8'h00;
        chk("fin_pulse", {127'b0, finished}, 128'd1);
        chk("fin_done", {120'b0, done}, '0);
        chk("fin_lanes", activations, '0);
        tick();
        chk("idle_fin", {127'b0, finished}, '0);
        chk("idle_busy", {127'b0, busy}, '0);
        chk("idle_done", {120'b0, done}, '0);

        // Rejected starts.
        for (int i = 0; i < 2; i++) begin
            start = 1'b1; cfg_k = i == 0 ? 4'd0 : 4'd9;
            tick();
            start = 1'b0;
            chk("cfg_err_pulse", {127'b0, cfg_err}, 128'd1);
            chk("cfg_err_busy", {127'b0, busy}, '0);
            chk("cfg_err_ready", {127'b0, load_ready}, '0);
            tick();
            chk("cfg_err_clear", {127'b0, cfg_err}, '0);
            chk("cfg_err_idle", {126'b0, busy, load_ready}, '0);
        end

        // K=1 with load gap, then drain timeout.
        start_tile(4'd1);
        load_tile(1, 'h0300, 'h0400, 3);
        load_valid = 1'b0;
        for (int t = 0; t < 9; t++) begin
            check_stream(t, 1, 'h0300, 'h0400);
            tick();
        end
        repeat (63) tick();
        chk("to_pre_err", {127'b0, timeout_err}, '0);
        chk("to_pre_done", {120'b0, done}, {120'b0, 8'hFF});
        chk("to_pre_busy", {127'b0, busy}, 128'd1);
        tick();
        chk("to_err", {127'b0, timeout_err}, 128'd1);
        chk("to_fin", {127'b0, finished}, 128'd1);
        tick();
        chk("to_idle_busy", {127'b0, busy}, '0);
        repeat (3) tick();
        chk("to_sticky", {127'b0, timeout_err}, 128'd1);
        start = 1'b1; cfg_k = 4'd0;
        tick();
        start = 1'b0;
        chk("to_sticky_cfgerr", {127'b0, timeout_err}, 128'd1);

        // K=2 with en dropped at t=5; early cluster_dones must be ignored.
        start_tile(4'd2);
        chk("to_cleared", {127'b0, timeout_err}, '0);
        load_tile(2, 'h0500, 'h0600, -1);
        load_valid = 1'b0;
        cluster_dones = 8'h80;
        for (int t = 0; t < 10; t++) begin
            check_stream(t, 2, 'h0500, 'h0600);
            if (t == 5) begin
                en = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    tick();
                    check_stream(5, 2, 'h0500, 'h0600);
                    chk("en0_ready", {127'b0, load_ready}, '0);
                end
                en = 1'b1;
            end
            tick();
        end
        chk("early_drain", {120'b0, done}, {120'b0, 8'hFF});
        tick();
        cluster_dones = 8'h00;
        chk("early_fin", {127'b0, finished}, 128'd1);
        tick();
        chk("early_idle", {127'b0, busy}, '0);

        // rst at STREAM t=6 discards the tile.
        start_tile(4'd4);
        load_tile(4, 'h0700, 'h0800, -1);
        load_valid = 1'b0;
        for (int t = 0; t < 7; t++) begin
            check_stream(t, 4, 'h0700, 'h0800);
            if (t < 6) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_lanes", activations | weights, '0);
        chk("mid_rst_done", {120'b0, done}, '0);
        chk("mid_rst_status", {123'b0, busy, finished, cfg_err, timeout_err, load_ready}, '0);
        start_tile(4'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pe_array_feeder.md
Name: pe_array_feeder

Overview:
- Sequencer that drives pe_8x8_cluster with skewed activation/weight wavefronts and per-row done flags.
- Buffers one ROWS x K tile, loaded serially as one activation/weight word pair per beat.
- Streams the tile into the cluster diagonally: lane r is delayed r cycles, followed by a sticky done[r].
- Waits for the cluster's last-row completion, then reports finished to the upstream controller.

Parameters:
- ROWS, 8, number of PE rows/lanes (fixed at 8 for pe_8x8_cluster).
- DATA_W, 16, width of one activation or weight word.
- MAX_K, 8, maximum reduction length per row (buffer depth per lane).
- TIMEOUT, 64, DRAIN cycles allowed before timeout_err.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- en  in  1  global enable; 0 freezes all state and outputs
- start  in  1  begin a tile; sampled in IDLE only
- cfg_k  in  4  reduction length K; latched on an accepted start
- load_valid  in  1  load beat valid
- load_ready  out  1  feeder accepts a load beat
- load_act  in  DATA_W  activation word
- load_wgt  in  DATA_W  weight word
- activations  out  ROWS*DATA_W  lane r on bits [r*DATA_W +: DATA_W], to cluster
- weights  out  ROWS*DATA_W  same lane packing, to cluster
- done  out  ROWS  per-row done flags, to cluster
- cluster_dones  in  ROWS  output_dones from cluster
- busy  out  1  high in any state except IDLE
- finished  out  1  one-cycle completion pulse
- cfg_err  out  1  one-cycle pulse on a rejected start
- timeout_err  out  1  sticky until next accepted start or rst

Behaviour:
- Reset (rst=1 at posedge): state IDLE; all outputs 0; buffer contents don't-care. rst overrides en.
- en=0: no state, counter, buffer or output changes; load_ready forced 0.
- All outputs are registered.
- States: IDLE, LOAD, STREAM, DRAIN, FIN.
- IDLE
  - start=1 with 1<=cfg_k<=MAX_K: latch K, clear timeout_err, go to LOAD.
  - start=1 with cfg_k=0 or cfg_k>MAX_K: pulse cfg_err, stay in IDLE.
  - start outside IDLE is ignored.
- LOAD
  - load_ready=1. A beat transfers when load_valid && load_ready.
  - Beat n (0..ROWS*K-1) is stored at row n/K, column n%K (row-major).
  - After the transfer of beat ROWS*K-1, load_ready drops in the next cycle and the state goes to STREAM.
  - load_valid gaps stall loading without limit.
- STREAM, with t = stream cycle index, t=0 in the first STREAM cycle:
  - When 0 <= t-r < K, lane r carries A[r][t-r] and W[r][t-r]; otherwise the lane is 0.
  - done[r] rises at t = r+K and stays high until FIN.
  - At t = ROWS-1+K, done[ROWS-1] rises; the next state is DRAIN.
  - Total STREAM length: ROWS+K cycles.
- DRAIN
  - Data lanes are 0; done holds all-ones.
  - Exit to FIN on cluster_dones[ROWS-1]=1.
  - After TIMEOUT DRAIN cycles without it: set timeout_err and go to FIN.
- FIN
  - finished=1 for exactly one cycle; done and lanes clear to 0.
  - Next state is IDLE; busy=0 from the next cycle.
  - A start in the cycle after FIN is accepted.
- Arithmetic: t counter is 5 bits, sized for ROWS+MAX_K. Data words pass unmodified; no arithmetic on data.
- K=1 boundary: lane r is active only at t=r, and done[r] rises at t=r+1.
- rst asserted mid-LOAD or mid-STREAM: next cycle is IDLE with outputs 0; the partial tile is discarded.
- cluster_dones[ROWS-1] asserted before DRAIN is ignored; only the DRAIN-state sample counts.

Test Plan:
1. rst=1 for 2 cycles, en=1, then start with cfg_k=4 and 32 beats with act=0x0100+n, wgt=0x0200+n.
   - STREAM t=0: lane0 act=0x0100.
   - t=3: lane3 act=0x010C, lane0 act=0x0103.
   - done[0] rises at t=4, done[7] at t=11.
   - STREAM lasts 12 cycles.
2. Continue 1: cluster_dones[7]=1 three cycles into DRAIN -> finished pulses exactly once; done=0x00 and busy=0 the cycle after the pulse.
3. start with cfg_k=0 and separately cfg_k=9 -> cfg_err single pulse each, busy stays 0, load_ready stays 0.
4. cfg_k=1 with a load gap (load_valid low for 5 cycles after beat 3) -> exactly 8 beats accepted; lane r nonzero only at t=r; done[7] rises at t=8.
5. cluster_dones never asserted -> timeout_err=1 after 64 DRAIN cycles, finished pulses, timeout_err held until the next valid start.
6. Drop en for 3 cycles mid-STREAM at t=5 -> all outputs frozen; the sequence resumes at t=5 unchanged.
7. Assert rst at STREAM t=6 -> next cycle all outputs 0, state IDLE.
